// File: rtl/alu_issue_queue.sv
// Command FIFO and issue stage in front of the combinational ADDU/SUBU ALU.
// Issues one command per cycle and holds the ALU result in a valid/ready register.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_instruction,
  input  logic [WIDTH-1:0]         in_op1,
  input  logic [WIDTH-1:0]         in_op2,
  output logic [WIDTH-1:0]         alu_op1,
  output logic [WIDTH-1:0]         alu_op2,
  output logic [1:0]               alu_instruction,
  output logic                     alu_enable,
  output logic                     alu_reset,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carryout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Both ports: a beat transfers on a rising edge where valid & ready are high;
  // data must be stable while valid is high and ready is low.

  typedef struct packed {
    logic [1:0]       instr;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           last_q, last_d;
  entry_t           head;
  entry_t           bus;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic             out_illegal_q, out_illegal_d;
  logic             push;
  logic             issue;
  logic             head_legal;
  state_e           state;

  assign head       = mem_q[rp_q];
  assign head_legal = ~head.instr[1];
  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign issue      = (count_q != '0) & (~out_valid_q | out_ready);

  // When empty the buses keep showing the last issued command.
  assign bus             = (count_q != '0) ? head : last_q;
  assign alu_op1         = bus.op1;
  assign alu_op2         = bus.op2;
  assign alu_instruction = bus.instr;
  assign alu_enable      = issue & head_legal & reset;
  assign alu_reset       = ~reset;

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_carry   = out_carry_q;
  assign out_illegal = out_illegal_q;
  assign count       = count_q;
  assign dbg_state   = state;

  always_comb begin
    mem_d         = mem_q;
    last_d        = last_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_carry_d   = out_carry_q;
    out_illegal_d = out_illegal_q;

    if (push) begin
      mem_d[wp_q] = '{instr: in_instruction, op1: in_op1, op2: in_op2};
      wp_d        = wp_q + AW'(1);
    end

    if (issue) begin
      rp_d        = rp_q + AW'(1);
      last_d      = head;
      out_valid_d = 1'b1;
      if (head_legal) begin
        out_result_d  = alu_result;
        out_carry_d   = alu_carryout;
        out_illegal_d = 1'b0;
      end else begin
        out_result_d  = '0;
        out_carry_d   = 1'b0;
        out_illegal_d = 1'b1;
      end
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end

    count_d = count_q + CW'(push) - CW'(issue);
  end

  always_comb begin
    state = ST_STALL;
    if (count_q == '0) begin
      state = out_valid_q ? ST_DRAIN : ST_IDLE;
    end else if (issue) begin
      state = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      last_q        <= '0;
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_carry_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      last_q        <= last_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_carry_q   <= out_carry_d;
      out_illegal_q <= out_illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: stub ALU plus a queue-based reference model and
// result scoreboard, driven by directed scenarios and randomized traffic.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;
  localparam int RW    = WIDTH + 2;

  typedef struct packed {
    logic [1:0]       ins;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_instruction;
  logic [WIDTH-1:0] in_op1, in_op2;
  logic [WIDTH-1:0] alu_op1, alu_op2;
  logic [1:0]       alu_instruction;
  logic             alu_enable, alu_reset;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry, out_illegal;
  logic [2:0]       count;
  logic [1:0]       dbg_state;
  logic [RW-1:0]    stub_r;

  int total = 0;
  int bad   = 0;

  cmd_t          cmd_q[$];
  logic [RW-1:0] exp_q[$];
  bit            mov;
  bit            p_rst, p_consume, p_issue, p_push;
  cmd_t          p_cmd;

  alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .in_op1(in_op1), .in_op2(in_op2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instruction(alu_instruction),
    .alu_enable(alu_enable), .alu_reset(alu_reset),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_illegal(out_illegal),
    .count(count), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {illegal, carry, result}. The ALU's flag is the inverted carry
  // for ADDU and the borrow for SUBU (5+3 -> 1, 0-1 -> 1).
  function automatic logic [RW-1:0] alu_ref(logic [1:0] ins, logic [WIDTH-1:0] a,
                                            logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (ins)
      2'b00:   return {1'b0, ~s[WIDTH], s[WIDTH-1:0]};
      2'b01:   return {1'b0, (a < b), a - b};
      default: return {1'b1, 1'b0, {WIDTH{1'b0}}};
    endcase
  endfunction

  // Stub ALU: garbage on its outputs whenever it is not enabled.
  always_comb begin
    stub_r = alu_ref(alu_instruction, alu_op1, alu_op2);
    if (alu_enable && !stub_r[RW-1]) begin
      alu_result   = stub_r[WIDTH-1:0];
      alu_carryout = stub_r[WIDTH];
    end else begin
      alu_result   = 64'hDEAD_BEEF_0BAD_F00D;
      alu_carryout = 1'b1;
    end
  end

  task automatic check(string tag, logic [RW-1:0] got, logic [RW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd64();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(logic v, logic [1:0] i, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    in_valid       = v;
    in_instruction = i;
    in_op1         = a;
    in_op2         = b;
  endtask

  task automatic check_cycle();
    int  n;
    bit  iss;
    bit  en;
    logic [1:0] st;
    n   = cmd_q.size();
    iss = (n != 0) && (!mov || out_ready);
    en  = reset && iss && !cmd_q[0].ins[1];
    if (n == 0) st = mov ? 2'd3 : 2'd0;
    else        st = iss ? 2'd1 : 2'd2;
    check("count", RW'(count), RW'(n));
    check("in_ready", RW'(in_ready), RW'(n != DEPTH));
    check("out_valid", RW'(out_valid), RW'(mov));
    check("alu_reset", RW'(alu_reset), RW'(!reset));
    check("alu_enable", RW'(alu_enable), RW'(en));
    check("dbg_state", RW'(dbg_state), RW'(st));
    if (n != 0) begin
      check("alu_instr", RW'(alu_instruction), RW'(cmd_q[0].ins));
      check("alu_op1", RW'(alu_op1), RW'(cmd_q[0].a));
      check("alu_op2", RW'(alu_op2), RW'(cmd_q[0].b));
    end
    if (mov && exp_q.size() != 0)
      check("out_data", {out_illegal, out_carry, out_result}, exp_q[0]);
    p_rst     = !reset;
    p_consume = mov && out_ready;
    p_issue   = iss;
    p_push    = in_valid && (n != DEPTH);
    p_cmd     = '{ins: in_instruction, a: in_op1, b: in_op2};
  endtask

  task automatic update_model();
    if (p_rst) begin
      cmd_q.delete();
      exp_q.delete();
      mov = 1'b0;
    end else begin
      if (p_consume) void'(exp_q.pop_front());
      if (p_issue) void'(cmd_q.pop_front());
      if (p_push) begin
        cmd_q.push_back(p_cmd);
        exp_q.push_back(alu_ref(p_cmd.ins, p_cmd.a, p_cmd.b));
      end
      if (p_issue)        mov = 1'b1;
      else if (p_consume) mov = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle(int n);
    drive(1'b0, 2'b00, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    mov       = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_count", RW'(count), '0);
    check("rst_out_valid", RW'(out_valid), '0);
    check("rst_out_data", {out_illegal, out_carry, out_result}, '0);
    check("rst_alu_reset", RW'(alu_reset), RW'(1));
    reset = 1'b1;
    idle(1);

    // single ADDU
    drive(1'b1, 2'b00, 64'd5, 64'd3);
    tick();
    idle(1);
    check("addu_valid", RW'(out_valid), RW'(1));
    check("addu_res", {out_illegal, out_carry, out_result}, {1'b0, 1'b1, 64'd8});
    idle(1);
    check("addu_drained", RW'(out_valid), '0);

    // SUBU wrap
    drive(1'b1, 2'b01, 64'd0, 64'd1);
    tick();
    idle(1);
    check("subu_res", {out_illegal, out_carry, out_result}, {1'b0, 1'b1, {WIDTH{1'b1}}});
    idle(2);

    // backpressure fill then drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'($urandom_range(0, 1)), rnd64(), rnd64());
      tick();
    end
    drive(1'b0, 2'b00, '0, '0);
    check("full_count", RW'(count), RW'(DEPTH));
    check("full_in_ready", RW'(in_ready), '0);
    idle(3);
    out_ready = 1'b1;
    idle(8);

    // continuous push/pop wrap-around
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'($urandom_range(0, 1)), rnd64(), rnd64());
      tick();
      check("wrap_count_le1", RW'(count <= 3'd1), RW'(1));
    end
    idle(3);

    // illegal code between two ADDUs
    drive(1'b1, 2'b00, 64'd10, 64'd20);
    tick();
    drive(1'b1, 2'b11, 64'd7, 64'd9);
    tick();
    drive(1'b1, 2'b00, '1, 64'd1);
    tick();
    check("illegal_res", {out_illegal, out_carry, out_result}, {1'b1, 1'b0, {WIDTH{1'b0}}});
    idle(4);

    // reset with three entries queued and a result held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, rnd64(), rnd64());
      tick();
    end
    check("pre_rst_count", RW'(count), RW'(3));
    reset = 1'b0;
    drive(1'b1, 2'b01, 64'd1, 64'd2);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    check("post_rst_count", RW'(count), '0);
    check("post_rst_valid", RW'(out_valid), '0);
    idle(4);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      logic [1:0] ins;
      reset     = ($urandom_range(0, 99) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      ins       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3))
                                              : 2'($urandom_range(0, 1));
      drive(($urandom_range(0, 9) < 7), ins, rnd64(), rnd64());
      tick();
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
